hazard_unit: RTL

Hazard and forwarding controller for the five-stage pipeline; the producer side of the ID/EX buffer's control interface. Keeps a shadow record of destination registers in flight in EX and MEM, compares it against the source registers of the instruction in ID, and drives the forward selects, the ID/EX bubble (`clear`), the IF/ID and PC hold (`stall`), and the branch flush. Also keeps saturating stall and flush event counters for debug readout.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/hazard_unit_if.sv | 33 +++
 rtl/hz_sat_counter.sv | 34 +++
 rtl/hazard_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline package: register constants, stage destination tag and
// the default hazard counter width.
package pipe_pkg;

  localparam logic [4:0] REG_X0    = 5'd0;
  localparam int         CNT_W_DEF = 16;

  // Destination record of an instruction occupying a pipeline stage.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit_if.sv
// Control interface between the ID stage, the hazard unit (master) and the
// ID/EX, IF/ID buffers and PC (slave).
interface hazard_unit_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use1;
  logic       id_use2;
  logic [4:0] id_rd;
  logic       id_RegWrite;
  logic       id_MemRead;
  logic       ex_branch_taken;

  logic       fwd_ex_1;
  logic       fwd_mem_1;
  logic       fwd_ex_2;
  logic       fwd_mem_2;
  logic       clear;
  logic       stall;
  logic       flush_if;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd,
           id_RegWrite, id_MemRead, ex_branch_taken,
    output fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2, clear, stall, flush_if
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd,
           id_RegWrite, id_MemRead, ex_branch_taken,
    input  fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2, clear, stall, flush_if
  );
endinterface

// File: rtl/hz_sat_counter.sv
// Saturating event counter clocked on the falling edge with a synchronous
// active-high reset, matching the pipeline stage buffers.
module hz_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(negedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the five-stage pipeline.
// Define HAZARD_FWD_EN for forwarding; otherwise every RAW dependency stalls.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  hazard_unit_if.master    hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_tag_t ex_q, ex_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic       mem_wr_q, mem_wr_d;

  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic hazard;
  logic stall_s, clear_s, flush_s;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a signal unassigned and infers a latch.
    ex_m1  = hz.id_valid && hz.id_use1 && (hz.id_rs1 != REG_X0) &&
             ex_q.wr && (ex_q.rd == hz.id_rs1);
    ex_m2  = hz.id_valid && hz.id_use2 && (hz.id_rs2 != REG_X0) &&
             ex_q.wr && (ex_q.rd == hz.id_rs2);
    mem_m1 = hz.id_valid && hz.id_use1 && (hz.id_rs1 != REG_X0) &&
             mem_wr_q && (mem_rd_q == hz.id_rs1);
    mem_m2 = hz.id_valid && hz.id_use2 && (hz.id_rs2 != REG_X0) &&
             mem_wr_q && (mem_rd_q == hz.id_rs2);

`ifdef HAZARD_FWD_EN
    // EX is the younger producer, so it wins over MEM; a load in EX has no
    // data yet and must be waited out for one cycle.
    hz.fwd_ex_1  = ex_m1 && !ex_q.ld;
    hz.fwd_ex_2  = ex_m2 && !ex_q.ld;
    hz.fwd_mem_1 = mem_m1 && !ex_m1;
    hz.fwd_mem_2 = mem_m2 && !ex_m2;
    hazard       = (ex_m1 || ex_m2) && ex_q.ld;
`else
    hz.fwd_ex_1  = 1'b0;
    hz.fwd_ex_2  = 1'b0;
    hz.fwd_mem_1 = 1'b0;
    hz.fwd_mem_2 = 1'b0;
    hazard       = ex_m1 || ex_m2 || mem_m1 || mem_m2;
`endif

    flush_s     = hz.ex_branch_taken;
    stall_s     = hazard && !flush_s;
    clear_s     = hazard || flush_s;
    hz.stall    = stall_s;
    hz.clear    = clear_s;
    hz.flush_if = flush_s;
  end

`ifndef HAZARD_FWD_EN
  logic unused_ex_ld;
  assign unused_ex_ld = ex_q.ld;
`endif

  always_comb begin
    mem_rd_d = ex_q.rd;
    mem_wr_d = ex_q.wr;
    ex_d     = TAG_BUBBLE;
    if (!(stall_s || clear_s || !hz.id_valid)) begin
      ex_d.rd = hz.id_rd;
      ex_d.wr = hz.id_RegWrite;
      ex_d.ld = hz.id_MemRead;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      ex_q     <= TAG_BUBBLE;
      mem_rd_q <= REG_X0;
      mem_wr_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
    end
  end

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_s),
    .cnt (stall_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_s),
    .cnt (flush_cnt)
  );

endmodule
